// File: rtl/seven_seg_pkg.sv
// Shared 7-segment constants and reader FSM state encoding.
// Patterns are active-low, bit6=a down to bit0=g.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] DIGIT_INVALID = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    HOLD
  } rd_state_e;

endpackage

// File: rtl/seven_seg_reader_if.sv
// Frame hand-off bundle: BCD digits, blank flags and valid/ready.
// The reader drives master, the consumer uses slave.
interface seven_seg_reader_if #(
  parameter int DIGITS = 4
) ();

  logic [4*DIGITS-1:0] frame_bcd;
  logic [DIGITS-1:0]   frame_blank;
  logic                frame_valid;
  logic                frame_ready;

  modport master (
    output frame_bcd,
    output frame_blank,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_bcd,
    input  frame_blank,
    input  frame_valid,
    output frame_ready
  );

endinterface

// File: rtl/seg_pattern_decoder.sv
// Maps an active-low segment pattern back to a BCD digit.
// Blank reads as digit 0 with blank set; unknown reads as 4'hF.
module seg_pattern_decoder
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg_n_i,
  output logic [3:0] digit_o,
  output logic       blank_o,
  output logic       invalid_o
);

  always_comb begin
    digit_o   = DIGIT_INVALID;
    blank_o   = 1'b0;
    invalid_o = 1'b0;
    unique case (seg_n_i)
      SEG_0:     digit_o = 4'd0;
      SEG_1:     digit_o = 4'd1;
      SEG_2:     digit_o = 4'd2;
      SEG_3:     digit_o = 4'd3;
      SEG_4:     digit_o = 4'd4;
      SEG_5:     digit_o = 4'd5;
      SEG_6:     digit_o = 4'd6;
      SEG_7:     digit_o = 4'd7;
      SEG_8:     digit_o = 4'd8;
      SEG_9:     digit_o = 4'd9;
      SEG_BLANK: begin
        digit_o = 4'd0;
        blank_o = 1'b1;
      end
      default:   invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_seg_reader.sv
// Passive readback of a multiplexed common-anode display bus.
// Settles, decodes each strobed digit and hands off whole frames.
module seven_seg_reader
  import seven_seg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        seg_n,
  input  logic [DIGITS-1:0] an_n,
  seven_seg_reader_if.master frm,
  output logic              decode_err,
  output logic              overrun,
  input  logic              clear_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);

  logic [6:0]          seg_m_q, seg_s_q, seg_p_q;
  logic [DIGITS-1:0]   an_m_q, an_s_q, an_p_q;
  rd_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic [4*DIGITS-1:0] slot_bcd_q, slot_bcd_d;
  logic [DIGITS-1:0]   slot_blk_q, slot_blk_d;
  logic [4*DIGITS-1:0] obcd_q, obcd_d;
  logic [DIGITS-1:0]   oblk_q, oblk_d;
  logic                vld_q, vld_d;
  logic                derr_q, derr_d;
  logic                ovr_q, ovr_d;

  logic       an_one, an_idle, an_multi, stable;
  logic       mask_full, cap_err, ovr_set;
  logic [3:0] dec_digit;
  logic       dec_blank, dec_inv;

  assign an_one    = $onehot(~an_s_q);
  assign an_idle   = &an_s_q;
  assign an_multi  = !an_one && !an_idle;
  assign stable    = (an_s_q == an_p_q) &&
                     (seg_s_q == seg_p_q);
  assign mask_full = &mask_q;

  // The previous-cycle copies hold the settled value during CAPTURE
  seg_pattern_decoder u_dec (
    .seg_n_i   (seg_p_q),
    .digit_o   (dec_digit),
    .blank_o   (dec_blank),
    .invalid_o (dec_inv)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    slot_bcd_d = slot_bcd_q;
    slot_blk_d = slot_blk_q;
    cap_err    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (an_one) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (!an_one) state_d = IDLE;
        else if (!stable) cnt_d = '0;
        else if (cnt_q == CNT_MAX) state_d = CAPTURE;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      CAPTURE: begin
        state_d = HOLD;
        cap_err = dec_inv;
        for (int k = 0; k < DIGITS; k++) begin
          if (!an_p_q[k]) begin
            slot_bcd_d[4*k +: 4] = dec_digit;
            slot_blk_d[k]        = dec_blank;
            mask_d[k]            = 1'b1;
          end
        end
      end
      HOLD: begin
        if (an_idle) state_d = IDLE;
        else if (an_one && (an_s_q != an_p_q)) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (mask_full) mask_d = '0;
    if (an_multi) begin
      state_d = IDLE;
      mask_d  = '0;
    end
  end

  always_comb begin
    obcd_d  = obcd_q;
    oblk_d  = oblk_q;
    vld_d   = vld_q;
    ovr_set = 1'b0;
    if (vld_q && frm.frame_ready) vld_d = 1'b0;
    if (mask_full) begin
      if (!vld_q || frm.frame_ready) begin
        obcd_d = slot_bcd_q;
        oblk_d = slot_blk_q;
        vld_d  = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end
    derr_d = clear_err ? 1'b0 : (derr_q | cap_err | an_multi);
    ovr_d  = clear_err ? 1'b0 : (ovr_q | ovr_set);
  end

  // Synchronisers idle high so reset never looks like a multi-anode strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_m_q    <= '1;
      seg_s_q    <= '1;
      seg_p_q    <= '1;
      an_m_q     <= '1;
      an_s_q     <= '1;
      an_p_q     <= '1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      mask_q     <= '0;
      slot_bcd_q <= '0;
      slot_blk_q <= '0;
      obcd_q     <= '0;
      oblk_q     <= '0;
      vld_q      <= 1'b0;
      derr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      seg_m_q    <= seg_n;
      seg_s_q    <= seg_m_q;
      seg_p_q    <= seg_s_q;
      an_m_q     <= an_n;
      an_s_q     <= an_m_q;
      an_p_q     <= an_s_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      slot_bcd_q <= slot_bcd_d;
      slot_blk_q <= slot_blk_d;
      obcd_q     <= obcd_d;
      oblk_q     <= oblk_d;
      vld_q      <= vld_d;
      derr_q     <= derr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign frm.frame_bcd   = obcd_q;
  assign frm.frame_blank = oblk_q;
  assign frm.frame_valid = vld_q;
  assign decode_err      = derr_q;
  assign overrun         = ovr_q;

endmodule

// File: doc/seven_seg_reader.md
Name: seven_seg_reader

Overview:
- Passive readback monitor for the multiplexed 4-digit common-anode 7-segment display bus.
- Samples active-low segment patterns per anode strobe after a settle window and decodes each back to BCD.
- Assembles one full scan into a BCD frame and hands it off on a valid/ready interface; used for self-check and loopback of the clock display path.

Parameters:
- DIGITS, 4, number of multiplexed digit positions (anode lines).
- SETTLE_CYCLES, 16, consecutive stable cycles of an_n and seg_n required before a digit is captured.
- CNT_W, 8, settle counter width; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- seg_n  input  7  segment bus, active-low, bit6=a … bit0=g.
- an_n  input  DIGITS  anode strobes, active-low, one-hot-low when a digit is driven.
- frame_bcd  output  4*DIGITS  captured digits; digit k in bits [4k+3:4k], k = anode index.
- frame_blank  output  DIGITS  1 = digit k was blank (seg_n = 7'b1111111).
- frame_valid  output  1  frame available; held until accepted.
- frame_ready  input  1  consumer accepts the frame when frame_valid & frame_ready.
- decode_err  output  1  sticky: an unrecognised pattern or multiple anodes were seen.
- overrun  output  1  sticky: a completed frame was dropped because the output was still held.
- clear_err  input  1  synchronous clear of decode_err and overrun.

Behaviour:
- One clock; reset is asynchronous and active-low. Clock port is clk, reset port is rst_n.
- Reset: state IDLE, capture mask 0, counter 0, frame_bcd 0, frame_blank 0, frame_valid 0, decode_err 0, overrun 0. Reset mid-scan discards partial captures.
- seg_n and an_n pass through a 2-flop synchroniser. All logic below uses the synchronised values.
- Pattern map (seg_n → digit):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4
  - 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9
  - 1111111 → digit 0, blank=1.
  - Any other pattern → digit 4'hF, blank=0, decode_err set.
- FSM IDLE:
  - Wait for exactly one an_n bit low, then go to SETTLE with counter 0.
  - All-high an_n (ghost-blanking gap) stays in IDLE; capture mask is kept.
- FSM SETTLE:
  - Increment the counter while an_n and seg_n equal their previous-cycle values. Any change resets the counter to 0.
  - If an_n becomes non-one-hot, go to IDLE.
  - When the counter reaches SETTLE_CYCLES-1, go to CAPTURE.
- FSM CAPTURE (1 cycle):
  - Decode seg_n into slot k and set mask bit k. Re-capturing the same k overwrites the slot.
  - Go to HOLD.
- FSM HOLD:
  - Stay while an_n is unchanged.
  - On an all-high an_n, go to IDLE.
  - On a different one-hot an_n, go to SETTLE with counter 0.
- Multiple anodes low in any state: set decode_err, clear the mask, go to IDLE.
- Latency: a digit is captured 2 + SETTLE_CYCLES + 1 cycles after its strobe reaches the pins, with a stable bus.
- Frame completion:
  - The cycle after the mask becomes all-ones, the mask clears.
  - If (!frame_valid | frame_ready): load frame_bcd and frame_blank, and set frame_valid = 1.
  - Otherwise drop the frame, set overrun, and leave the outputs unchanged.
- Handshake:
  - frame_bcd and frame_blank are stable while frame_valid = 1.
  - Accept with no new frame in the same cycle: frame_valid → 0 next cycle.
  - Accept and new frame in the same cycle: load the new frame and keep frame_valid = 1 (no bubble, no overrun).
- clear_err has priority over a same-cycle set: the flags clear, and the new event is lost.

Decomposition:
- Package seven_seg_pkg holds:
  - SEG_0..SEG_9 and SEG_BLANK 7-bit constants (shared with the display encoder).
  - DIGIT_INVALID = 4'hF.
  - The FSM state enum (IDLE, SETTLE, CAPTURE, HOLD).
- One combinational sub-module, seg_pattern_decoder: 7-bit pattern → {digit[3:0], blank, invalid}.
- The FSM, synchroniser, mask and output handshake stay in seven_seg_reader.

Test Plan:
1. Scan digits 1,2,5,9 on an_n 1110,1101,1011,0111, each held 40 cycles, ready = 1 → one frame_valid pulse; frame_bcd = 16'h9521, frame_blank = 0, no errors.
2. Strobe held only SETTLE_CYCLES-2 cycles → no capture, no frame. Then a seg_n glitch at cycle 10 of a 40-cycle hold → capture occurs after the glitch, value correct.
3. Digit 2 driven 1111111 and digit 0 driven 1111110 → frame_blank = 4'b0100, digit 0 = F, decode_err = 1. clear_err → decode_err = 0.
4. Hold ready = 0 across two full scans (3,4,5,6 then 7,8,9,0) → frame_bcd stays 16'h6543, overrun = 1. Ready pulse → frame_valid drops.
5. an_n = 1100 mid-scan → decode_err = 1 and mask cleared; next frame needs all four digits recaptured.
6. Assert rst_n low during the third digit's SETTLE → all outputs 0 immediately. After release, a full scan gives a correct frame.
